// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the core
// load/store path and a request/acknowledge backing memory port.
module data_cache #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned SETS          = 16,
  parameter int unsigned LINE_WORDS    = 4,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [ADDRESS_WIDTH-1:0]   A,
  input  logic                       MemRead,
  input  logic                       MemWrite,
  input  logic [DATA_WIDTH/8-1:0]    BE,
  input  logic [DATA_WIDTH-1:0]      WD,
  output logic [DATA_WIDTH-1:0]      RD,
  output logic                       Stall,
  output logic                       MReq,
  output logic                       MWe,
  output logic [ADDRESS_WIDTH-1:0]   MAddr,
  output logic [DATA_WIDTH-1:0]      MWD,
  output logic [DATA_WIDTH/8-1:0]    MBE,
  input  logic [DATA_WIDTH-1:0]      MRD,
  input  logic                       MAck,
  output logic [CNT_WIDTH-1:0]       HitCount,
  output logic [CNT_WIDTH-1:0]       MissCount
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned WS_W  = $clog2(LINE_WORDS);
  localparam int unsigned WS_B  = (WS_W == 0) ? 1 : WS_W;
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDRESS_WIDTH - 2 - WS_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t                   state_q, state_d;
  logic [WS_B-1:0]          beat_q, beat_d;
  logic [IDX_W-1:0]         refill_idx_q;
  logic [TAG_W-1:0]         refill_tag_q;
  logic [SETS-1:0]          valid_q;
  logic [TAG_W-1:0]         tag_q  [SETS];
  logic [DATA_WIDTH-1:0]    data_q [SETS][LINE_WORDS];

  logic                     mreq_d, mwe_d;
  logic [ADDRESS_WIDTH-1:0] maddr_d;
  logic [DATA_WIDTH-1:0]    mwd_d;
  logic [BE_W-1:0]          mbe_d;
  logic                     hit_inc, miss_inc, store_hit, refill_we, refill_done;

  logic [WS_B-1:0]          a_ws;
  logic [IDX_W-1:0]         a_idx;
  logic [TAG_W-1:0]         a_tag;
  logic                     hit, ack;
  logic [DATA_WIDTH-1:0]    merged;

  // Address decomposition via shifts so LINE_WORDS=1 needs no zero-width slice
  assign a_ws  = WS_B'((A >> 2) & ADDRESS_WIDTH'(LINE_WORDS - 1));
  assign a_idx = IDX_W'((A >> (2 + WS_W)) & ADDRESS_WIDTH'(SETS - 1));
  assign a_tag = TAG_W'(A >> (2 + WS_W + IDX_W));
  assign hit   = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign RD    = data_q[a_idx][a_ws];
  assign ack   = MReq && MAck;

  // Store-hit byte-lane merge
  always_comb begin
    merged = data_q[a_idx][a_ws];
    for (int i = 0; i < int'(BE_W); i++) begin
      if (BE[i]) merged[8*i +: 8] = WD[8*i +: 8];
    end
  end

  // Next-state, next registered outputs, stall
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    mreq_d      = MReq;
    mwe_d       = MWe;
    maddr_d     = MAddr;
    mwd_d       = MWD;
    mbe_d       = MBE;
    Stall       = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    store_hit   = 1'b0;
    refill_we   = 1'b0;
    refill_done = 1'b0;
    case (state_q)
      IDLE: begin
        Stall = MemWrite || (MemRead && !hit);
        if (MemWrite) begin
          state_d   = WRITE;
          mreq_d    = 1'b1;
          mwe_d     = 1'b1;
          maddr_d   = A & ~ADDRESS_WIDTH'(3);
          mwd_d     = WD;
          mbe_d     = BE;
          store_hit = hit;
        end else if (MemRead && !hit) begin
          state_d  = REFILL;
          beat_d   = '0;
          mreq_d   = 1'b1;
          mwe_d    = 1'b0;
          maddr_d  = A & ~ADDRESS_WIDTH'(LINE_WORDS * 4 - 1);
          miss_inc = 1'b1;
        end else if (MemRead) begin
          hit_inc = 1'b1;
        end
      end
      REFILL: begin
        Stall = 1'b1;
        if (ack) begin
          refill_we = 1'b1;
          maddr_d   = MAddr + ADDRESS_WIDTH'(4);
          beat_d    = beat_q + WS_B'(1);
          if (beat_q == WS_B'(LINE_WORDS - 1)) begin
            refill_done = 1'b1;
            mreq_d      = 1'b0;
            beat_d      = '0;
            state_d     = IDLE;
          end
        end
      end
      WRITE: begin
        Stall = !MAck;
        if (ack) begin
          mreq_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, memory port registers, valid bits, counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      refill_idx_q <= '0;
      refill_tag_q <= '0;
      valid_q      <= '0;
      MReq         <= 1'b0;
      MWe          <= 1'b0;
      MAddr        <= '0;
      MWD          <= '0;
      MBE          <= '0;
      HitCount     <= '0;
      MissCount    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      MReq    <= mreq_d;
      MWe     <= mwe_d;
      MAddr   <= maddr_d;
      MWD     <= mwd_d;
      MBE     <= mbe_d;
      if (miss_inc) begin
        refill_idx_q <= a_idx;
        refill_tag_q <= a_tag;
      end
      if (refill_done) valid_q[refill_idx_q] <= 1'b1;
      if (hit_inc && HitCount != '1)   HitCount  <= HitCount + CNT_WIDTH'(1);
      if (miss_inc && MissCount != '1) MissCount <= MissCount + CNT_WIDTH'(1);
    end
  end

  // Line storage; a partially filled line stays invalid so needs no reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (refill_we) data_q[refill_idx_q][beat_q] <= MRD;
      if (refill_done) tag_q[refill_idx_q] <= refill_tag_q;
      if (store_hit) data_q[a_idx][a_ws] <= merged;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache with a behavioural backing memory.
module tb_data_cache;

  logic        CLK, RST;
  logic [31:0] A;
  logic        MemRead, MemWrite;
  logic [3:0]  BE;
  logic [31:0] WD, RD;
  logic        Stall, MReq, MWe;
  logic [31:0] MAddr, MWD;
  logic [3:0]  MBE;
  logic [31:0] MRD;
  logic        MAck;
  logic [31:0] HitCount, MissCount;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] raddr [$];

  data_cache dut (
    .CLK(CLK), .RST(RST), .A(A), .MemRead(MemRead), .MemWrite(MemWrite),
    .BE(BE), .WD(WD), .RD(RD), .Stall(Stall), .MReq(MReq), .MWe(MWe),
    .MAddr(MAddr), .MWD(MWD), .MBE(MBE), .MRD(MRD), .MAck(MAck),
    .HitCount(HitCount), .MissCount(MissCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Untouched memory words hold 0x13570000 + address
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h1357_0000 + a;
  endfunction

  always @(negedge CLK) MRD = mem_rd(MAddr);

  always @(posedge CLK) begin
    if (MReq && MWe && MAck) begin
      logic [31:0] w;
      w = mem_rd(MAddr);
      for (int i = 0; i < 4; i++) if (MBE[i]) w[8*i +: 8] = MWD[8*i +: 8];
      mem[MAddr] = w;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load held until Stall drops; returns stall cycles and hit-cycle RD
  task automatic load(input logic [31:0] addr, output int stalls, output logic [31:0] rd);
    raddr.delete();
    A = addr; MemRead = 1'b1; MemWrite = 1'b0; stalls = 0;
    #1;
    while (Stall && stalls < 50) begin
      stalls++;
      @(posedge CLK); #1;
      if (MReq && !MWe) raddr.push_back(MAddr);
    end
    rd = RD;
    @(posedge CLK); #1;
    MemRead = 1'b0;
  endtask

  // Store whose MAck arrives after `delay` WRITE cycles
  task automatic store(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                       input int delay, output int stalls);
    MAck = (delay == 0); A = addr; WD = wd; BE = be; MemWrite = 1'b1; MemRead = 1'b0;
    #1;
    stalls = Stall ? 1 : 0;
    @(posedge CLK); #1;
    for (int i = 0; i < delay; i++) begin
      chk("wr_hold_mreq", {31'd0, MReq}, 32'd1);
      chk("wr_hold_maddr", MAddr, addr & ~32'd3);
      if (Stall) stalls++;
      @(posedge CLK); #1;
    end
    MAck = 1'b1; #1;
    chk("wr_mreq", {31'd0, MReq}, 32'd1);
    chk("wr_mwe", {31'd0, MWe}, 32'd1);
    chk("wr_maddr", MAddr, addr & ~32'd3);
    chk("wr_mwd", MWD, wd);
    chk("wr_mbe", {28'd0, MBE}, {28'd0, be});
    if (Stall) stalls++;
    @(posedge CLK); #1;
    MemWrite = 1'b0;
    chk("wr_done_mreq", {31'd0, MReq}, 32'd0);
  endtask

  int          st;
  logic [31:0] rd;

  initial begin
    RST = 1'b1; A = '0; MemRead = 1'b0; MemWrite = 1'b0; BE = '0; WD = '0; MAck = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_mreq", {31'd0, MReq}, 32'd0);
    chk("rst_mwe", {31'd0, MWe}, 32'd0);
    chk("rst_maddr", MAddr, 32'd0);
    chk("rst_mwd", MWD, 32'd0);
    chk("rst_mbe", {28'd0, MBE}, 32'd0);
    chk("rst_hits", HitCount, 32'd0);
    chk("rst_misses", MissCount, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    RST = 1'b0;

    // Cold miss with MAck every cycle
    MAck = 1'b1;
    load(32'h100, st, rd);
    chk("miss_stall", st, 5);
    chk("miss_nbeats", raddr.size(), 4);
    for (int i = 0; i < 4 && i < raddr.size(); i++)
      chk("miss_beat_addr", raddr[i], 32'h100 + 32'(4 * i));
    chk("miss_rd", rd, 32'h1357_0100);
    chk("miss_cnt1", MissCount, 32'd1);
    chk("hit_cnt1", HitCount, 32'd1);

    load(32'h104, st, rd);
    chk("hit_stall", st, 0);
    chk("hit_rd", rd, 32'h1357_0104);
    chk("hit_cnt2", HitCount, 32'd2);

    // Store hit updates byte 1 only
    store(32'h104, 32'hAABB_CCDD, 4'b0010, 0, st);
    chk("st_hit_stall", st, 1);
    load(32'h104, st, rd);
    chk("st_hit_ld_stall", st, 0);
    chk("st_hit_rd", rd, 32'h1357_CC04);
    chk("hit_cnt3", HitCount, 32'd3);

    // Store miss, slow ack, no allocate
    store(32'h2000, 32'h1122_3344, 4'b1111, 3, st);
    chk("st_miss_stall", st, 4);
    MAck = 1'b1;
    load(32'h2000, st, rd);
    chk("st_miss_ld_stall", st, 5);
    chk("st_miss_ld_rd", rd, 32'h1122_3344);
    chk("miss_cnt2", MissCount, 32'd2);
    chk("hit_cnt4", HitCount, 32'd4);

    // Reset during beat 2 of a refill
    A = 32'h100; MemRead = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end
    chk("mid_beat2_maddr", MAddr, 32'h108);
    chk("mid_beat2_mreq", {31'd0, MReq}, 32'd1);
    RST = 1'b1; MemRead = 1'b0;
    @(posedge CLK); #1;
    chk("abort_mreq", {31'd0, MReq}, 32'd0);
    chk("abort_hits", HitCount, 32'd0);
    chk("abort_misses", MissCount, 32'd0);
    RST = 1'b0;

    // Conflict misses on index 0
    load(32'h100, st, rd);
    chk("reld_stall", st, 5);
    chk("reld_rd", rd, 32'h1357_0100);
    load(32'h500, st, rd);
    chk("conf_stall", st, 5);
    chk("conf_rd", rd, 32'h1357_0500);
    load(32'h100, st, rd);
    chk("conf_back_stall", st, 5);
    chk("conf_back_rd", rd, 32'h1357_0100);
    chk("conf_misses", MissCount, 32'd3);
    chk("conf_hits", HitCount, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
